// File: rtl/gate3_tt_sequencer_pkg.sv
// Shared definitions for the 3-input gate truth-table sequencer:
// state encoding, vector sizing and the standard expected tables.
package gate_tt_pkg;

  localparam int NUM_VECTORS = 8;
  localparam int IDX_W       = 3;
  localparam int CNT_W       = 4;

  localparam logic [NUM_VECTORS-1:0] TT_AND3  = 8'h80;
  localparam logic [NUM_VECTORS-1:0] TT_NAND3 = 8'h7F;
  localparam logic [NUM_VECTORS-1:0] TT_OR3   = 8'hFE;
  localparam logic [NUM_VECTORS-1:0] TT_NOR3  = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } tt_state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  function automatic logic vectorMismatch(input logic [NUM_VECTORS-1:0] table_v,
                                          input logic [IDX_W-1:0]       idx,
                                          input logic                   observed);
    return observed != table_v[idx];
  endfunction

endpackage

// File: rtl/gate3_tt_sequencer_if.sv
// Control, gate-stimulus and result signals between the sequencer (master)
// and its environment / gate under test (slave).
interface gate3_tt_sequencer_if;
  import gate_tt_pkg::*;

  logic                   start;
  logic                   abort;
  logic                   dut_out;
  logic                   a;
  logic                   b;
  logic                   c;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [3:0]             err_count;
  logic [NUM_VECTORS-1:0] fail_mask;
  logic [NUM_VECTORS-1:0] captured;

  modport master (
    input  start, abort, dut_out,
    output a, b, c, busy, done, pass, err_count, fail_mask, captured
  );

  modport slave (
    output start, abort, dut_out,
    input  a, b, c, busy, done, pass, err_count, fail_mask, captured
  );

endinterface

// File: rtl/gate3_tt_sequencer_settle_timer.sv
// Loadable down-counter that parks at zero; zero is asserted while the count is 0.
module tt_settle_timer
  import gate_tt_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/gate3_tt_sequencer.sv
// Steps a 3-input gate through all eight input vectors, holds each for
// SETTLE_CYCLES, samples the gate and scores it against EXPECTED.
module gate3_tt_sequencer
  import gate_tt_pkg::*;
#(
  parameter int unsigned            SETTLE_CYCLES = 2,
  parameter logic [NUM_VECTORS-1:0] EXPECTED      = TT_AND3
) (
  input  logic                 clk,
  input  logic                 rst,
  gate3_tt_sequencer_if.master bus
);

  tt_state_e              state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [IDX_W-1:0]       abc_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   pass_q;
  logic [3:0]             errCount_q;
  logic [3:0]             errCount_d;
  logic [NUM_VECTORS-1:0] failMask_q;
  logic [NUM_VECTORS-1:0] captured_q;

  logic sampleMiss;
  logic startReq;
  logic timerLoad;
  logic timerZero;

  // abort blocks a start in the same cycle, and suppresses the reload
  // that would otherwise accompany the move to the next vector.
  assign sampleMiss = vectorMismatch(EXPECTED, idx_q, bus.dut_out);
  assign startReq   = bus.start && !bus.abort &&
                      ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign timerLoad  = startReq ||
                      ((state_q == ST_SAMPLE) && !bus.abort && (idx_q != LAST_IDX));
  assign errCount_d = errCount_q + 4'(sampleMiss);

  tt_settle_timer #(
    .W (CNT_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timerLoad),
    .load_val (CNT_W'(SETTLE_CYCLES - 1)),
    .zero     (timerZero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      abc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      errCount_q <= '0;
      failMask_q <= '0;
      captured_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (startReq) begin
            state_q    <= ST_SETTLE;
            idx_q      <= '0;
            abc_q      <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            errCount_q <= '0;
            failMask_q <= '0;
            captured_q <= '0;
          end
        end

        ST_SETTLE: begin
          if (bus.abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else if (timerZero) begin
            state_q <= ST_SAMPLE;
          end
        end

        ST_SAMPLE: begin
          if (bus.abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else begin
            captured_q[idx_q] <= bus.dut_out;
            if (sampleMiss) begin
              failMask_q[idx_q] <= 1'b1;
            end
            errCount_q <= errCount_d;
            if (idx_q == LAST_IDX) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (errCount_d == 4'd0);
            end else begin
              state_q <= ST_SETTLE;
              idx_q   <= idx_q + IDX_W'(1);
              abc_q   <= idx_q + IDX_W'(1);
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a         = abc_q[2];
  assign bus.b         = abc_q[1];
  assign bus.c         = abc_q[0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = errCount_q;
  assign bus.fail_mask = failMask_q;
  assign bus.captured  = captured_q;

endmodule

// File: doc/gate3_tt_sequencer.md
Name: gate3_tt_sequencer

Overview:
- Synthesizable controller that sequences an exhaustive truth-table run on any 3-input combinational gate under test (cmos_and3, nand3, or3, nor3 and similar).
- Drives the eight input vectors in binary order, waits a programmable settle time per vector, samples the gate output, and compares it against an expected table.
- Reports per-vector mismatches, a mismatch count and pass/done flags.
- Sits beside the gate under test and replaces hand-written #5 stimulus lists with a clocked, self-checking sequence.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..15.
- EXPECTED, 8'h80, expected output per vector index; bit i is the output for {a,b,c}=i. 8'h80 is AND3.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  begin a run; sampled in IDLE or DONE only
- abort  input  1  terminate a run in progress
- dut_out  input  1  output of the gate under test
- a  output  1  gate input a; vector index bit 2
- b  output  1  gate input b; vector index bit 1
- c  output  1  gate input c; vector index bit 0
- busy  output  1  run in progress
- done  output  1  run completed; held high until the next start
- pass  output  1  done and zero mismatches
- err_count  output  4  number of mismatching vectors, 0..8
- fail_mask  output  8  bit i set when vector i mismatched
- captured  output  8  observed output per vector

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, idx=0, {a,b,c}=000.
  - busy, done and pass are 0.
  - err_count, fail_mask and captured are 0.
  - Reset asserted mid-run forces the same values immediately. No partial results survive.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - {a,b,c} holds its last value (000 after reset).
  - start=1 causes the following on the next edge: idx=0; results cleared; settle counter loaded with SETTLE_CYCLES-1; state goes to SETTLE.
- SETTLE:
  - {a,b,c}=idx and busy=1.
  - The counter decrements each cycle. When the counter is 0, the next state is SAMPLE.
  - SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle):
  - captured[idx] <= dut_out.
  - If dut_out != EXPECTED[idx]: fail_mask[idx] <= 1 and err_count += 1.
  - If idx==7, go to DONE. Otherwise idx += 1, reload the counter, and go to SETTLE.
  - The new vector appears on {a,b,c} in the cycle after SAMPLE.
- DONE:
  - busy=0 and done=1.
  - pass=1 when the final err_count==0, registered on entry to DONE.
  - Outputs, results and {a,b,c}=111 are held.
  - start=1 restarts a run exactly as from IDLE and clears done/pass in the same edge.
- Latency:
  - Each vector takes SETTLE_CYCLES+1 cycles.
  - The edge that samples start is followed by 8*(SETTLE_CYCLES+1) cycles with busy=1, then done=1.
  - With the defaults, busy is high for 24 cycles.
- start while busy: ignored.
- abort while busy:
  - State goes to IDLE on the next edge; busy=0 and done=0.
  - fail_mask, captured and err_count hold their partial values. pass=0.
  - abort has priority over the SAMPLE update in the same cycle; that vector is not recorded.
- start and abort together in IDLE/DONE: abort wins and no run starts.
- err_count cannot exceed 8, so no saturation logic is needed.
- idx wraps only by a new start, never by overflow.
- dut_out is sampled only in SAMPLE. It is ignored elsewhere.

Decomposition:
- Shared package gate_tt_pkg:
  - State encoding constants.
  - NUM_VECTORS=8 and the vector-index width of 3.
  - Expected-table constants TT_AND3=8'h80, TT_NAND3=8'h7F, TT_OR3=8'hFE, TT_NOR3=8'h01.
- One natural sub-module: tt_settle_timer.
  - Loadable down-counter with inputs load and load_val, and output zero.
  - Instantiated once for the SETTLE countdown.

Test Plan:
- DUT cmos_and3, defaults. Pulse start for one cycle. Required response: busy for 24 cycles; {a,b,c} steps 000..111, each held 3 cycles; done=1; pass=1; captured=8'h80; fail_mask=8'h00; err_count=0.
- dut_out tied to 0 with EXPECTED=TT_AND3. Required response: done=1; pass=0; captured=8'h00; fail_mask=8'h80; err_count=1.
- cmos_nand3 as DUT with EXPECTED=TT_AND3. Required response: captured=8'h7F; fail_mask=8'hFF; err_count=8; pass=0.
- Pulse start again at cycle 5 of a run. Required response: ignored; completion still 24 cycles after the first start. A start pulse in DONE restarts the run and clears done/pass on that edge.
- Faulty DUT (stuck-at-1). Assert abort during SAMPLE of vector 3. Required response: idle next cycle; busy=0; done=0; fail_mask=8'h07; err_count=3; captured[3] not written.
- Assert rst asynchronously (between clock edges) during SETTLE of vector 5. Required response: all outputs 0 and {a,b,c}=000 before the next clock edge. A following start runs cleanly to pass=1 with the correct DUT.
